// File: rtl/posit_pkg.sv
// Shared posit<8,0> constants and the dot-sequencer state encoding.
package posit_pkg;

  localparam int unsigned POSIT_W = 8;
  localparam logic [POSIT_W-1:0] POSIT_ZERO = 8'h00;
  localparam logic [POSIT_W-1:0] POSIT_NAR  = 8'h80;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_t;

endpackage

// File: rtl/posit_mac_8bit.sv
// Combinational fused posit<8,0> multiply-add: result = a*b + c, rounded once (RNE).
// Every posit<8,0> value is a multiple of 2^-6, so the exact sum fits a fixed-point word.
module posit_mac_8bit
  import posit_pkg::*;
(
  input  logic [POSIT_W-1:0] a,
  input  logic [POSIT_W-1:0] b,
  input  logic [POSIT_W-1:0] c,
  output logic [POSIT_W-1:0] result
);

  // Magnitude of a non-zero positive posit body, in units of 2^-6.
  function automatic logic [12:0] dec_mag(input logic [6:0] body);
    int m;
    int k;
    int nf;
    int val;
    logic run;
    logic [6:0] frac;
    m   = 0;
    run = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      if (run && (body[i] == body[6])) m++;
      else run = 1'b0;
    end
    k    = body[6] ? m - 1 : -m;
    nf   = (m >= 6) ? 0 : 6 - m;
    frac = body & 7'((1 << nf) - 1);
    val  = ((1 << nf) + int'(frac)) << (k + 6 - nf);
    return 13'(val);
  endfunction

  // Round a non-zero magnitude (units of 2^-12) to a positive posit body.
  // Builds the unbounded regime+fraction bit string, then RNE on bit 7; saturates both ends.
  function automatic logic [6:0] enc_mag(input logic [27:0] mag);
    int p;
    int k;
    int rl;
    logic [63:0] fext;
    logic [63:0] regv;
    logic [63:0] s;
    logic [6:0] top;
    logic [6:0] res;
    logic up;
    p = 0;
    for (int i = 0; i < 28; i++) begin
      if (mag[i]) p = i;
    end
    k = p - 12;
    if (k >= 6) begin
      res = 7'h7F;
    end else if (k < -6) begin
      res = 7'h01;
    end else begin
      fext = {36'd0, mag} << (64 - p);
      if (k >= 0) begin
        rl   = k + 2;
        regv = ~(64'hFFFF_FFFF_FFFF_FFFF >> (k + 1));
      end else begin
        rl   = 1 - k;
        regv = 64'd1 << (63 + k);
      end
      s   = regv | (fext >> rl);
      top = s[63:57];
      up  = s[56] & ((|s[55:0]) | top[0]);
      res = top + 7'(up);
    end
    return res;
  endfunction

  logic [6:0]         ua, ub, uc;
  logic [12:0]        ma, mb, mc;
  logic [25:0]        prod;
  logic signed [27:0] sprod, sc, sum;
  logic [27:0]        mag;
  logic [6:0]         enc;

  // Decode operands, form the exact sum, then round once.
  always_comb begin
    ua    = a[7] ? (~a[6:0] + 7'd1) : a[6:0];
    ub    = b[7] ? (~b[6:0] + 7'd1) : b[6:0];
    uc    = c[7] ? (~c[6:0] + 7'd1) : c[6:0];
    ma    = (a == POSIT_ZERO) ? 13'd0 : dec_mag(ua);
    mb    = (b == POSIT_ZERO) ? 13'd0 : dec_mag(ub);
    mc    = (c == POSIT_ZERO) ? 13'd0 : dec_mag(uc);
    prod  = 26'(ma) * 26'(mb);
    sprod = (a[7] ^ b[7]) ? -$signed({2'b00, prod}) : $signed({2'b00, prod});
    sc    = c[7] ? -$signed({9'd0, mc, 6'd0}) : $signed({9'd0, mc, 6'd0});
    sum   = sprod + sc;
    mag   = sum[27] ? (~sum + 28'd1) : sum;
    enc   = (mag == 28'd0) ? 7'd0 : enc_mag(mag);
    if ((a == POSIT_NAR) || (b == POSIT_NAR) || (c == POSIT_NAR)) begin
      result = POSIT_NAR;
    end else if (mag == 28'd0) begin
      result = POSIT_ZERO;
    end else begin
      result = sum[27] ? (~{1'b0, enc} + 8'd1) : {1'b0, enc};
    end
  end

endmodule

// File: rtl/posit_dot_sequencer.sv
// Dot-product sequencer: takes a length command, streams operand pairs through the MAC
// against a private accumulator, and holds the result on a valid/ready output.
module posit_dot_sequencer
  import posit_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [POSIT_W-1:0] in_a,
  input  logic [POSIT_W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POSIT_W-1:0] out_data,
  output logic               nar_seen,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [POSIT_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [POSIT_W-1:0] out_data_q, out_data_d;
  logic               nar_q, nar_d;
  logic [POSIT_W-1:0] mac;
  logic               beat;
  logic               accept;

  posit_mac_8bit u_mac (
    .a      (in_a),
    .b      (in_b),
    .c      (acc_q),
    .result (mac)
  );

  // Outputs decoded from state/registers; command accept also covers the DONE handshake.
  always_comb begin
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_data  = out_data_q;
    nar_seen  = nar_q;
    beat      = in_valid & in_ready;
    accept    = start & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  end

  // Next-state logic for the FSM, counter, accumulator and result register.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    nar_d      = nar_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          acc_d = POSIT_ZERO;
          nar_d = 1'b0;
          cnt_d = len;
          if (len != '0) begin
            state_d = StAccum;
          end else begin
            state_d    = StDone;
            out_data_d = POSIT_ZERO;
          end
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StAccum: begin
        if (beat) begin
          acc_d = mac;
          cnt_d = cnt_q - LEN_W'(1);
          nar_d = nar_q | (in_a == POSIT_NAR) | (in_b == POSIT_NAR) | (mac == POSIT_NAR);
          if (cnt_q == LEN_W'(1)) begin
            out_data_d = mac;
            state_d    = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= POSIT_ZERO;
      cnt_q      <= '0;
      out_data_q <= POSIT_ZERO;
      nar_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      nar_q      <= nar_d;
    end
  end

endmodule

// File: tb/tb_posit_dot_sequencer.sv
// Bench for posit_dot_sequencer: real-valued posit model plus directed dot products.
module tb_posit_dot_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       nar_seen;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  posit_dot_sequencer #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .nar_seen  (nar_seen),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Posit<8,0> value from its definition: sign, regime run, fraction.
  function automatic real p2r(input logic [7:0] p);
    logic [7:0] u;
    int run, k, nf;
    real f, v;
    if (p == 8'h00) return 0.0;
    u   = p[7] ? (~p + 8'd1) : p;
    run = 1;
    while (run < 7 && u[6-run] == u[6]) run++;
    k  = u[6] ? run - 1 : -run;
    nf = 6 - run;
    if (nf < 0) nf = 0;
    f = 0.0;
    for (int i = 0; i < nf; i++) if (u[i]) f += 2.0 ** (i - nf);
    v = (2.0 ** k) * (1.0 + f);
    return p[7] ? -v : v;
  endfunction

  // Nearest posit, ties to even code, saturating at minpos/maxpos.
  function automatic logic [7:0] r2p(input real v);
    real a, lo, hi;
    logic [7:0] c, code;
    if (v == 0.0) return 8'h00;
    a    = (v < 0.0) ? -v : v;
    code = 8'h01;
    if (a >= 64.0) begin
      code = 8'h7F;
    end else if (a > 1.0 / 64.0) begin
      for (int i = 1; i < 127; i++) begin
        c  = 8'(i);
        lo = p2r(c);
        hi = p2r(c + 8'd1);
        if (a >= lo && a < hi) begin
          if (a - lo < hi - a) code = c;
          else if (a - lo > hi - a) code = c + 8'd1;
          else code = c[0] ? c + 8'd1 : c;
        end
      end
    end
    return (v < 0.0) ? (~code + 8'd1) : code;
  endfunction

  function automatic logic [7:0] mac_m(input logic [7:0] a, b, c);
    if (a == 8'h80 || b == 8'h80 || c == 8'h80) return 8'h80;
    return r2p(p2r(a) * p2r(b) + p2r(c));
  endfunction

  // Transaction-level model: phase 0 idle, 1 collecting pairs, 2 holding a result.
  int         m_phase = 0;
  int         m_left  = 0;
  logic [7:0] m_out   = 8'h00;
  logic       m_nar   = 1'b0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  initial forever begin
    logic hs;
    logic [7:0] acc;
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_out = 8'h00; m_nar = 1'b0;
      qa.delete(); qb.delete();
    end else begin
      hs = (m_phase == 2) && out_ready;
      if (m_phase == 1 && in_valid) begin
        qa.push_back(in_a); qb.push_back(in_b);
        m_left--;
        if (m_left == 0) begin
          acc = 8'h00; m_nar = 1'b0;
          foreach (qa[i]) begin
            acc   = mac_m(qa[i], qb[i], acc);
            m_nar = m_nar | (qa[i] == 8'h80) | (qb[i] == 8'h80) | (acc == 8'h80);
          end
          m_out   = acc;
          m_phase = 2;
        end
      end else if (start && (m_phase == 0 || hs)) begin
        qa.delete(); qb.delete();
        m_nar = 1'b0;
        if (len == 8'd0) begin
          m_out = 8'h00; m_phase = 2;
        end else begin
          m_left = int'(len); m_phase = 1;
        end
      end else if (hs) begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle compare against the model, on the falling edge.
  int rdy_cycles = 0;
  int beats      = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      check("in_ready", in_ready, m_phase == 1);
      check("out_valid", out_valid, m_phase == 2);
      check("busy", busy, m_phase != 0);
      check("out_data", out_data, m_out);
      if (m_phase == 2) check("nar_seen", nar_seen, m_nar);
      if (in_ready) rdy_cycles++;
      if (in_ready && in_valid) beats++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [7:0] l);
    start = 1'b1; len = l;
    tick;
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick;
    in_valid = 1'b1; in_a = a; in_b = b;
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    check("pair_ready", in_ready, 1'b1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [7:0] want, input logic want_nar);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_data"}, out_data, want);
    check({name, "_nar"}, nar_seen, want_nar);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;
    tick; tick;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_nar", nar_seen, 1'b0);
    rst_n = 1'b1; chk_en = 1'b1;

    // Pin the model with hand-computed values.
    check("m_1x1", mac_m(8'h40, 8'h40, 8'h00), 8'h40);
    check("m_1x1p1", mac_m(8'h40, 8'h40, 8'h40), 8'h60);
    check("m_neg", mac_m(8'hC0, 8'h40, 8'h40), 8'h00);
    check("m_2x2", mac_m(8'h60, 8'h60, 8'h00), 8'h70);
    check("m_sat", mac_m(8'h7F, 8'h7F, 8'h00), 8'h7F);
    check("m_minpos", mac_m(8'h01, 8'h01, 8'h00), 8'h01);

    // 1: 1*1 + 1*1 = 2, in_valid held high past the end.
    b0 = beats;
    do_cmd(8'd2);
    in_valid = 1'b1; in_a = 8'h40; in_b = 8'h40;
    repeat (4) tick;
    in_valid = 1'b0;
    check("t1_beats", 32'(beats - b0), 32'd2);
    wait_result("t1", 8'h60, 1'b0);

    // 2: zero length.
    rdy_cycles = 0;
    do_cmd(8'd0);
    check("t2_latency", out_valid, 1'b1);
    wait_result("t2", 8'h00, 1'b0);
    check("t2_no_ready", 32'(rdy_cycles), 32'd0);

    // 3: 2 - 1 + 0 with gaps.
    do_cmd(8'd3);
    send_pair(8'h60, 8'h40, 2);
    send_pair(8'hC0, 8'h40, 1);
    send_pair(8'h00, 8'h70, 3);
    check("t3_latency", out_valid, 1'b1);
    check("t3_data", out_data, 8'h40);

    // 4: hold in DONE with start ignored, then back-to-back command.
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 8'd5;
      tick;
      check("t4_hold_data", out_data, 8'h40);
      check("t4_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1; start = 1'b1; len = 8'd1;
    tick;
    out_ready = 1'b0; start = 1'b0;
    check("t4_b2b_ready", in_ready, 1'b1);
    check("t4_b2b_valid", out_valid, 1'b0);
    send_pair(8'h60, 8'h60, 0);
    check("t4_latency", out_valid, 1'b1);
    wait_result("t4", 8'h70, 1'b0);

    // 5: NaR absorbs, then the next dot clears the flag.
    do_cmd(8'd2);
    send_pair(8'h80, 8'h40, 0);
    send_pair(8'h40, 8'h40, 1);
    wait_result("t5", 8'h80, 1'b1);
    do_cmd(8'd1);
    send_pair(8'h40, 8'h40, 0);
    wait_result("t5_clear", 8'h40, 1'b0);

    // 6: reset mid-dot discards the partial sum.
    do_cmd(8'd3);
    send_pair(8'h40, 8'h40, 0);
    rst_n = 1'b0;
    tick;
    check("t6_in_ready", in_ready, 1'b0);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_out_data", out_data, 8'h00);
    check("t6_nar", nar_seen, 1'b0);
    rst_n = 1'b1;
    do_cmd(8'd1);
    send_pair(8'h70, 8'h40, 0);
    wait_result("t6", 8'h70, 1'b0);

    tick; tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
